// File: rtl/seg7_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scanner.
package seg7_pkg;

    localparam int NIB_W      = 4;
    // Widest display lz_mask can evaluate; larger DIGITS must raise this.
    localparam int MAX_DIGITS = 16;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    // Bit i is set when digit i is a leading zero: i > 0 and nibbles
    // i..digits-1 are all zero. Digit 0 is never flagged.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [NIB_W*MAX_DIGITS-1:0] value,
        input int                          digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  upper_zero;
        mask       = '0;
        upper_zero = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < digits) begin
                upper_zero = upper_zero && (value[NIB_W*i +: NIB_W] == '0);
                mask[i]    = (i > 0) && upper_zero;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg7_scan_tick.sv
// Reloadable down-counter: tick is high while the count sits at zero, and
// tick_next tells the parent whether the following cycle will tick.
module scan_tick #(
    parameter int               CNT_W    = 2,
    parameter logic [CNT_W-1:0] RST_LOAD = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick,
    output logic             tick_next
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is assigned with <= only, so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= RST_LOAD;
        end else if (tick) begin
            cnt <= load_val;
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tick      = (cnt == '0);
    assign tick_next = tick ? (load_val == '0) : (cnt == CNT_W'(1));

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed scanner for a common-anode 7-segment display with
// anti-ghost blanking, leading-zero suppression and frame-aligned updates.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int CLK_DIV     = 50000,
    parameter int BLANK_CYC   = 500,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NIB_W*DIGITS-1:0] val,
    input  logic                    val_ld,
    output logic [NIB_W-1:0]        dig_dat,
    output logic                    dig_enb,
    output logic [DIGITS-1:0]       dig_sel,
    output logic                    frame_done
);

    localparam int CNT_MAX   = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int CNT_RANGE = (CNT_MAX > 2) ? CNT_MAX : 2;
    localparam int CNT_W     = $clog2(CNT_RANGE);
    localparam int IDX_RANGE = (DIGITS > 2) ? DIGITS : 2;
    localparam int IDX_W     = $clog2(IDX_RANGE);

    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGITS - 1);
    localparam logic             HAS_BLANK  = (BLANK_CYC > 0);
    localparam logic             LZ_ON      = (LZ_SUPPRESS != 0);

    state_t                    state;
    state_t                    nxt_state;
    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          nxt_idx;
    logic [NIB_W*DIGITS-1:0]   shadow;
    logic [NIB_W*DIGITS-1:0]   nxt_shadow;
    logic [NIB_W*DIGITS-1:0]   pend;
    logic                      pending;
    logic                      wrap;
    logic                      tick;
    logic                      tick_next;
    logic [CNT_W-1:0]          load_val;

    logic [NIB_W*MAX_DIGITS-1:0] wide_shadow;
    logic [MAX_DIGITS-1:0]       sup_mask;
    logic [DIGITS-1:0]           nxt_sel;
    logic [NIB_W-1:0]            nxt_dat;
    logic                        nxt_enb;
    logic                        nxt_frame_done;

    scan_tick #(
        .CNT_W   (CNT_W),
        .RST_LOAD(BLANK_LOAD)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .load_val (load_val),
        .tick     (tick),
        .tick_next(tick_next)
    );

    // Sequencing: where the scan goes on the next edge, and which value the
    // display will hold from then on (shadow only moves at the index wrap).
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        nxt_state  = state;
        nxt_idx    = idx;
        wrap       = 1'b0;
        nxt_shadow = shadow;
        if (tick) begin
            if (state == BLANK) begin
                nxt_state = SHOW;
            end else begin
                if (HAS_BLANK) begin
                    nxt_state = BLANK;
                end else begin
                    nxt_state = SHOW;
                end
                wrap    = (idx == LAST_IDX);
                nxt_idx = wrap ? '0 : idx + IDX_W'(1);
            end
        end
        load_val = (nxt_state == SHOW) ? SHOW_LOAD : BLANK_LOAD;
        if (wrap) begin
            if (val_ld) begin
                nxt_shadow = val;
            end else if (pending) begin
                nxt_shadow = pend;
            end
        end
    end

    // Output decode for the state being entered, so outputs leave a register.
    always_comb begin
        wide_shadow                      = '0;
        wide_shadow[NIB_W*DIGITS-1:0]    = nxt_shadow;
        sup_mask                         = lz_mask(wide_shadow, DIGITS);
        nxt_sel                          = '1;
        nxt_dat                          = '0;
        nxt_enb                          = 1'b0;
        if (nxt_state == SHOW) begin
            nxt_sel[nxt_idx] = 1'b0;
            nxt_dat          = nxt_shadow[NIB_W*nxt_idx +: NIB_W];
            nxt_enb          = !(LZ_ON && sup_mask[nxt_idx]);
        end
        // The last cycle of the final digit is the one in which idx wraps.
        nxt_frame_done = (nxt_state == SHOW) && (nxt_idx == LAST_IDX) && tick_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BLANK;
            idx        <= '0;
            shadow     <= '0;
            pend       <= '0;
            pending    <= 1'b0;
            dig_sel    <= '1;
            dig_enb    <= 1'b0;
            dig_dat    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= nxt_state;
            idx        <= nxt_idx;
            shadow     <= nxt_shadow;
            if (wrap) begin
                pending <= 1'b0;
            end else if (val_ld) begin
                pend    <= val;
                pending <= 1'b1;
            end
            dig_sel    <= nxt_sel;
            dig_enb    <= nxt_enb;
            dig_dat    <= nxt_dat;
            frame_done <= nxt_frame_done;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: directed scenarios plus random loads/resets, checked
// every cycle against a timeline model built from cycle arithmetic.
module tb_seg7_scan;

    localparam int DIGITS    = 4;
    localparam int CLK_DIV   = 4;
    localparam int BLANK_CYC = 1;
    localparam int P         = BLANK_CYC + CLK_DIV;  // per-digit period
    localparam int F         = DIGITS * P;           // frame period

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [4*DIGITS-1:0]   val = '0;
    logic                  val_ld = 1'b0;
    logic [3:0]            dig_dat;
    logic                  dig_enb;
    logic [DIGITS-1:0]     dig_sel;
    logic                  frame_done;

    seg7_scan #(
        .DIGITS     (DIGITS),
        .CLK_DIV    (CLK_DIV),
        .BLANK_CYC  (BLANK_CYC),
        .LZ_SUPPRESS(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .val       (val),
        .val_ld    (val_ld),
        .dig_dat   (dig_dat),
        .dig_enb   (dig_enb),
        .dig_sel   (dig_sel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int t           = 0;   // index of the current cycle since the last reset edge
    bit model_valid = 1'b0;

    typedef struct {
        int                t;
        logic [4*DIGITS-1:0] v;
    } load_t;
    load_t loads[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, t, got, exp);
        end
    endtask

    // Frame k displays the newest value loaded in any cycle before k*F.
    function automatic logic [4*DIGITS-1:0] frame_value(input int k);
        logic [4*DIGITS-1:0] r;
        r = '0;
        foreach (loads[i]) begin
            if (loads[i].t < k * F) r = loads[i].v;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            loads.delete();
            model_valid = 1'b1;
        end else begin
            if (val_ld) loads.push_back('{t, val});
            t++;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            int                  d;
            int                  ph;
            bit                  show;
            logic [4*DIGITS-1:0] v;
            logic [3:0]          nib;
            logic [DIGITS-1:0]   exp_sel;
            d    = (t / P) % DIGITS;
            ph   = t % P;
            show = (ph >= BLANK_CYC);
            v    = frame_value(t / F);
            nib  = 4'((v >> (4 * d)) & 'hF);
            exp_sel = '1;
            if (show) exp_sel[d] = 1'b0;
            check("dig_sel", 32'(dig_sel), 32'(exp_sel));
            check("dig_dat", 32'(dig_dat), show ? 32'(nib) : 32'd0);
            check("dig_enb", 32'(dig_enb),
                  32'(show && (d == 0 || (v >> (4 * d)) != 0)));
            check("frame_done", 32'(frame_done), 32'((t % F) == F - 1));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4*DIGITS-1:0] v);
        val    = v;
        val_ld = 1'b1;
        @(posedge clk);
        #1;
        val_ld = 1'b0;
    endtask

    // Advance until the current cycle sits at the given offset within a frame.
    task automatic goto_phase(input int phase);
        for (int i = 0; i < F; i++) begin
            if (t % F == phase) break;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset held over three edges, then the first SHOW one cycle later.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cycles(3);

        // Scan order and frame cadence.
        load(16'h1234);
        wait_cycles(45);

        // Leading-zero suppression.
        load(16'h0050);
        wait_cycles(45);
        load(16'h0000);
        wait_cycles(45);

        // Tear-free update and last-load-wins.
        load(16'hABCD);
        wait_cycles(45);
        goto_phase(2 * P + 2);
        load(16'h1111);
        wait_cycles(40);
        goto_phase(3);
        load(16'h2222);
        wait_cycles(5);
        load(16'h3333);
        wait_cycles(45);

        // Load in the frame_done cycle is taken without an extra frame.
        goto_phase(F - 1);
        load(16'h5678);
        wait_cycles(25);

        // Reset mid-SHOW discards a pending value.
        load(16'h9999);
        wait_cycles(25);
        goto_phase(P + 2);
        load(16'h4321);
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(45);

        // Random loads biased toward leading zeros, with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                wait_cycles($urandom_range(1, 2));
                rst = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                load(16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4))));
            end else begin
                wait_cycles(1);
            end
        end
        wait_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
